// File: rtl/bk_multiword_add_seq_pkg.sv
// rtl/bk_multiword_add_seq_pkg.sv - shared types and helpers for the multiword add sequencer
package bk_multiword_add_seq_pkg;

   // Sequencer states; the unused code 2'd3 is steered back to ST_IDLE
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADD  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Word index width: enough to count WORDS words, never narrower than one bit
   function automatic int idx_width(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/bk_multiword_add_seq_bk_adder.sv
// rtl/bk_multiword_add_seq_bk_adder.sv - combinational 2**N-bit Brent-Kung adder
module bkAdderParam #(
   parameter int N = 5
) (
   input  logic [(1<<N)-1:0] a,
   input  logic [(1<<N)-1:0] b,
   input  logic              cin,
   output logic [(1<<N)-1:0] sum,
   output logic              cout
);

   localparam int W = 1 << N;

   // Up-sweep then down-sweep prefix tree yields group generate/propagate from bit 0
   always_comb begin : prefix
      logic [W-1:0] p;
      logic [W-1:0] gg;
      logic [W-1:0] pp;
      logic [W-1:0] c;
      int           j;
      p  = a ^ b;
      gg = a & b;
      pp = p;
      for (int l = 0; l < N; l++) begin
         for (int i = 0; i < W; i++) begin
            j = (i >= (1 << l)) ? i - (1 << l) : 0;
            if (((i + 1) % (1 << (l + 1))) == 0) begin
               gg[i] = gg[i] | (pp[i] & gg[j]);
               pp[i] = pp[i] & pp[j];
            end
         end
      end
      for (int l = N - 2; l >= 0; l--) begin
         for (int i = 0; i < W; i++) begin
            j = (i >= (1 << l)) ? i - (1 << l) : 0;
            if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1)))) begin
               gg[i] = gg[i] | (pp[i] & gg[j]);
               pp[i] = pp[i] & pp[j];
            end
         end
      end
      c[0] = cin;
      for (int i = 1; i < W; i++) begin
         c[i] = gg[i-1] | (pp[i-1] & cin);
      end
      sum  = p ^ c;
      cout = gg[W-1] | (pp[W-1] & cin);
   end

endmodule

// File: rtl/bk_multiword_add_seq.sv
// rtl/bk_multiword_add_seq.sv - word-serial wide add/subtract around one Brent-Kung adder
module bk_multiword_add_seq
   import bk_multiword_add_seq_pkg::*;
#(
   parameter int N     = 5,
   parameter int WORDS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WORDS*(1<<N)-1:0]   in_a,
   input  logic [WORDS*(1<<N)-1:0]   in_b,
   input  logic                      in_cin,
   input  logic                      in_sub,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WORDS*(1<<N)-1:0]   out_sum,
   output logic                      out_cout,
   output logic                      out_ovf,
   output logic                      out_zero
);

   localparam int W  = 1 << N;
   localparam int IW = idx_width(WORDS);
   localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

   state_t                    state;
   logic [IW-1:0]             idx;
   logic                      carry;
   logic [WORDS-1:0][W-1:0]   a_q;
   logic [WORDS-1:0][W-1:0]   b_q;
   logic [WORDS-1:0][W-1:0]   sum_q;
   logic [WORDS-1:0][W-1:0]   sum_next;
   logic [W-1:0]              word_sum;
   logic                      word_cout;
   logic                      take;

   bkAdderParam #(.N(N)) u_adder (
      .a    (a_q[idx]),
      .b    (b_q[idx]),
      .cin  (carry),
      .sum  (word_sum),
      .cout (word_cout)
   );

   // Accept in IDLE, or in DONE only when the result leaves in the same cycle
   always_comb begin
      in_ready = 1'b0;
      if (rst_n) begin
         case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
         endcase
      end
   end

   assign take    = in_valid & in_ready;
   assign out_sum = sum_q;

   // Sum register image after the current word is written, used for the zero flag
   always_comb begin
      sum_next      = sum_q;
      sum_next[idx] = word_sum;
   end

   // Sequencer: load operands, add one word per edge, hold the result until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         idx       <= '0;
         carry     <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         out_valid <= 1'b0;
         out_cout  <= 1'b0;
         out_ovf   <= 1'b0;
         out_zero  <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               if (take) begin
                  a_q   <= in_a;
                  b_q   <= in_sub ? ~in_b : in_b;
                  carry <= in_sub | in_cin;
                  idx   <= '0;
                  state <= ST_ADD;
               end
            end
            ST_ADD: begin
               sum_q <= sum_next;
               carry <= word_cout;
               idx   <= idx + 1'b1;
               if (idx == LAST) begin
                  idx       <= '0;
                  out_cout  <= word_cout;
                  out_ovf   <= (a_q[WORDS-1][W-1] == b_q[WORDS-1][W-1]) &&
                               (word_sum[W-1] != a_q[WORDS-1][W-1]);
                  out_zero  <= (sum_next == '0);
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     a_q   <= in_a;
                     b_q   <= in_sub ? ~in_b : in_b;
                     carry <= in_sub | in_cin;
                     idx   <= '0;
                     state <= ST_ADD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bk_multiword_add_seq.sv
// tb/tb_bk_multiword_add_seq.sv - scoreboard bench for the multiword add sequencer
module tb_bk_multiword_add_seq;

   localparam int N     = 5;
   localparam int WORDS = 4;
   localparam int TW    = WORDS * (1 << N);

   typedef struct packed {
      logic [TW-1:0] sum;
      logic          cout;
      logic          ovf;
      logic          zero;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [TW-1:0] in_a;
   logic [TW-1:0] in_b;
   logic          in_cin;
   logic          in_sub;
   logic          out_valid;
   logic          out_ready;
   logic [TW-1:0] out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic          out_zero;

   exp_t exp_q[$];
   int   acc_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;
   bit   rand_mode = 0;
   logic prev_valid = 1'b0;

   bk_multiword_add_seq #(.N(N), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_sub    (in_sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: plain wide arithmetic on the operands as integers
   function automatic exp_t model(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                  input logic cin, input logic sub);
      exp_t          e;
      logic [TW:0]   u;
      logic [TW+1:0] s;
      logic [TW+1:0] sa;
      logic [TW+1:0] sb;
      sa = {{2{a[TW-1]}}, a};
      sb = {{2{b[TW-1]}}, b};
      if (sub) begin
         u      = {1'b0, a} - {1'b0, b};
         e.cout = (a >= b);
         s      = sa - sb;
      end else begin
         u      = {1'b0, a} + {1'b0, b} + (TW+1)'(cin);
         e.cout = u[TW];
         s      = sa + sb + (TW+2)'(cin);
      end
      e.sum  = u[TW-1:0];
      e.ovf  = (s[TW] != s[TW-1]);
      e.zero = (e.sum == '0);
      return e;
   endfunction

   function automatic logic [TW-1:0] rand_word();
      logic [TW-1:0] v;
      for (int k = 0; k < TW / 32; k++) v[k*32 +: 32] = $urandom;
      case ($urandom_range(0, 5))
         0: v = '1;
         1: v = '0;
         2: v = {1'b1, {(TW-1){1'b0}}};
         3: v = TW'($urandom_range(0, 9));
         default: ;
      endcase
      return v;
   endfunction

   // Called just after a rising edge; returns after the accepting edge
   task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b,
                        input logic cin, input logic sub, output int waits);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      waits    = 0;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waits++;
         if (waits > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready stuck low after %0d cycles", waits);
            in_valid = 1'b0;
            return;
         end
         @(posedge clk);
         #1;
         if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
      end
      exp_q.push_back(model(a, b, cin, sub));
      @(posedge clk);
      #1;
      acc_q.push_back(cyc);
      in_valid = 1'b0;
      in_a     = rand_word();
      in_b     = rand_word();
      in_cin   = 1'($urandom);
      in_sub   = 1'($urandom);
      if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic drain();
      int t = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && t < 100) begin
         @(posedge clk);
         t++;
      end
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: latency on each rising out_valid, content on each result transfer
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid <= 1'b0;
      end else begin
         if (out_valid && !prev_valid) begin
            if (acc_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL latency: out_valid rose with no accepted operation");
            end else begin
               chk("latency", TW'(cyc - acc_q.pop_front()), TW'(WORDS));
            end
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_result: got sum %h with no expected entry", out_sum);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sum", out_sum, e.sum);
               chk("cout", TW'(out_cout), TW'(e.cout));
               chk("ovf", TW'(out_ovf), TW'(e.ovf));
               chk("zero", TW'(out_zero), TW'(e.zero));
            end
         end
         prev_valid <= out_valid;
      end
   end

   initial begin
      int w;
      int t;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", TW'(out_valid), '0);
      chk("rst_in_ready", TW'(in_ready), '0);
      chk("rst_out_zero", TW'(out_zero), TW'(1));
      chk("rst_out_sum", out_sum, '0);
      chk("rst_flags", TW'({out_cout, out_ovf}), '0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", TW'(in_ready), TW'(1));

      // Carry ripple across three word boundaries
      @(posedge clk);
      #1;
      issue({32'h0, 96'hFFFFFFFF_FFFFFFFF_FFFFFFFF}, 128'd1, 1'b0, 1'b0, w);
      // Full wrap to zero
      issue('1, '0, 1'b1, 1'b0, w);
      // Subtract with borrow, and signed overflow on subtract
      issue(128'd5, 128'd7, 1'b0, 1'b1, w);
      issue({1'b1, 127'h0}, 128'd1, 1'b0, 1'b1, w);
      drain();

      // Backpressure, then simultaneous result and operand transfer
      out_ready = 1'b0;
      issue(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000,
            1'b1, 1'b0, w);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!out_valid && t < 50);
      chk("bp_valid_seen", TW'(out_valid), TW'(1));
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_valid_held", TW'(out_valid), TW'(1));
         chk("bp_in_ready", TW'(in_ready), '0);
         if (exp_q.size() != 0) chk("bp_sum_stable", out_sum, exp_q[0].sum);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      issue(128'hDEAD_BEEF, 128'h1, 1'b0, 1'b0, w);
      chk("b2b_accept_waits", TW'(w), '0);
      drain();

      // Reset in the middle of an add, then a clean 3+4
      issue('1, 128'd1, 1'b0, 1'b0, w);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      exp_q.delete();
      acc_q.delete();
      @(negedge clk);
      chk("midrst_out_valid", TW'(out_valid), '0);
      chk("midrst_in_ready", TW'(in_ready), '0);
      chk("midrst_out_zero", TW'(out_zero), TW'(1));
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("midrst_no_result", TW'(out_valid), '0);
      @(posedge clk);
      #1;
      issue(128'd3, 128'd4, 1'b0, 1'b0, w);
      drain();

      // Randomized traffic with random sink stalls
      rand_mode = 1;
      for (int k = 0; k < 40; k++) begin
         issue(rand_word(), rand_word(), 1'($urandom), 1'($urandom), w);
      end
      rand_mode = 0;
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
